// File: rtl/fir_seq_mac.sv
// fir_seq_mac: sequential single-MAC FIR engine.
// Each accepted sample is written into a private delay line. The block then
// walks NTAPS coefficients from the read port of the coefficient DPRAM, one
// per cycle, and emits one rounded, saturated output sample.
// Optional build macro FIR_SAT_CNT_EN adds an 8-bit sticky saturation counter
// output (sat_cnt).
module fir_seq_mac #(
    parameter int NTAPS     = 64,
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int ACC_W     = 44,
    parameter int OUT_SHIFT = 17,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [6:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] dout,
    output logic                     dout_valid
`ifdef FIR_SAT_CNT_EN
    ,
    output logic [7:0]               sat_cnt
`endif
);

    localparam int PW = DATA_W + COEF_W;
    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int RS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic [KW-1:0] LAST_K = KW'(NTAPS - 1);
    localparam logic [6:0] BASE7 = 7'(BASE_ADDR);
    localparam logic signed [ACC_W-1:0] RND =
        (OUT_SHIFT > 0) ? (ACC_W'(1) << RS) : '0;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

    state_t state, next_state;

    logic signed [DATA_W-1:0] delay [NTAPS];
    logic [KW-1:0]            wptr;
    logic [KW-1:0]            rd_idx;
    logic [KW-1:0]            k;
    logic signed [DATA_W-1:0] x_reg;
    logic                     mac_valid;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [PW-1:0]     x_ext;
    logic signed [PW-1:0]     c_ext;
    logic signed [PW-1:0]     prod;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic signed [DATA_W-1:0] sat_val;

    function automatic logic [KW-1:0] wrap_inc(input logic [KW-1:0] v);
        return (v == LAST_K) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [KW-1:0] wrap_dec(input logic [KW-1:0] v);
        return (v == '0) ? LAST_K : v - 1'b1;
    endfunction

    // The coefficient address follows the tap counter, which rests at 0 when idle
    assign coef_addr = BASE7 + 7'(k);

    // Full-precision product of the aligned sample/coefficient pair, then the
    // running sum, rounding, shift and saturation of the final result
    always_comb begin
        x_ext    = {{COEF_W{x_reg[DATA_W-1]}}, x_reg};
        c_ext    = {{DATA_W{coef_data[COEF_W-1]}}, coef_data};
        prod     = x_ext * c_ext;
        acc_sum  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
        rounded  = acc_sum + RND;
        shifted  = rounded >>> OUT_SHIFT;
        clamp_hi = shifted > SAT_MAX;
        clamp_lo = shifted < SAT_MIN;
        if (clamp_hi)
            sat_val = SAT_MAX[DATA_W-1:0];
        else if (clamp_lo)
            sat_val = SAT_MIN[DATA_W-1:0];
        else
            sat_val = shifted[DATA_W-1:0];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        next_state = state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                din_ready = !reset;
                if (din_valid && !reset)
                    next_state = MAC;
            end
            MAC: begin
                if (k == LAST_K)
                    next_state = FLUSH;
            end
            FLUSH: next_state = OUT;
            OUT: begin
                dout_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: delay line write, tap walk, sample alignment and accumulation.
    // wptr names the slot the next sample lands in; rd_idx walks backwards
    // from the newest sample so that x[n-k] lines up with h[k].
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++)
                delay[i] <= '0;
            wptr      <= '0;
            rd_idx    <= '0;
            k         <= '0;
            x_reg     <= '0;
            mac_valid <= 1'b0;
            acc       <= '0;
            dout      <= '0;
        end else begin
            mac_valid <= (state == MAC);
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        delay[wptr] <= din;
                        rd_idx      <= wptr;
                        wptr        <= wrap_inc(wptr);
                        acc         <= '0;
                        k           <= '0;
                    end
                end
                MAC: begin
                    x_reg  <= delay[rd_idx];
                    rd_idx <= wrap_dec(rd_idx);
                    k      <= wrap_inc(k);
                    if (mac_valid)
                        acc <= acc_sum;
                end
                FLUSH: begin
                    acc  <= acc_sum;
                    dout <= sat_val;
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_SAT_CNT_EN
    // Sticky count of outputs that had to be clamped
    always_ff @(posedge clock) begin
        if (reset)
            sat_cnt <= '0;
        else if (state == FLUSH && (clamp_hi || clamp_lo) && sat_cnt != 8'hFF)
            sat_cnt <= sat_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: directed bench for fir_seq_mac with four configurations
// (64 taps unscaled, 1 tap rounding, 4 taps wrap, 64 taps saturation).
module tb_fir_seq_mac;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                rst_v  [4];
    logic signed [17:0]  din_v  [4];
    logic                dval_v [4];
    logic                rdy_v  [4];
    logic                ov_v   [4];
    logic signed [17:0]  dout_v [4];
    logic [6:0]          addr_v [4];

    logic rdy_a, rdy_b, rdy_c, rdy_d;
    logic ov_a, ov_b, ov_c, ov_d;
    logic [6:0] addr_a, addr_b, addr_c, addr_d;
    logic signed [17:0] cdat_a, cdat_b, cdat_c, cdat_d;
    logic signed [17:0] dout_a, dout_b, dout_c, dout_d;
`ifdef FIR_SAT_CNT_EN
    logic [7:0] satc_a, satc_b, satc_c, satc_d;
`endif

    logic signed [17:0] rom [4][128];

    int tests = 0;
    int fails = 0;

    fir_seq_mac #(.NTAPS(64), .OUT_SHIFT(0)) u_a (
        .clock(clock), .reset(rst_v[0]), .din(din_v[0]), .din_valid(dval_v[0]),
        .din_ready(rdy_a), .coef_addr(addr_a), .coef_data(cdat_a),
        .dout(dout_a), .dout_valid(ov_a)
`ifdef FIR_SAT_CNT_EN
        , .sat_cnt(satc_a)
`endif
    );

    fir_seq_mac #(.NTAPS(1), .OUT_SHIFT(17)) u_b (
        .clock(clock), .reset(rst_v[1]), .din(din_v[1]), .din_valid(dval_v[1]),
        .din_ready(rdy_b), .coef_addr(addr_b), .coef_data(cdat_b),
        .dout(dout_b), .dout_valid(ov_b)
`ifdef FIR_SAT_CNT_EN
        , .sat_cnt(satc_b)
`endif
    );

    fir_seq_mac #(.NTAPS(4), .OUT_SHIFT(0)) u_c (
        .clock(clock), .reset(rst_v[2]), .din(din_v[2]), .din_valid(dval_v[2]),
        .din_ready(rdy_c), .coef_addr(addr_c), .coef_data(cdat_c),
        .dout(dout_c), .dout_valid(ov_c)
`ifdef FIR_SAT_CNT_EN
        , .sat_cnt(satc_c)
`endif
    );

    fir_seq_mac #(.NTAPS(64), .OUT_SHIFT(17)) u_d (
        .clock(clock), .reset(rst_v[3]), .din(din_v[3]), .din_valid(dval_v[3]),
        .din_ready(rdy_d), .coef_addr(addr_d), .coef_data(cdat_d),
        .dout(dout_d), .dout_valid(ov_d)
`ifdef FIR_SAT_CNT_EN
        , .sat_cnt(satc_d)
`endif
    );

    // Registered coefficient read ports (one-cycle latency DPRAM model)
    always @(posedge clock) begin
        cdat_a <= rom[0][addr_a];
        cdat_b <= rom[1][addr_b];
        cdat_c <= rom[2][addr_c];
        cdat_d <= rom[3][addr_d];
    end

    // Gather per-instance outputs so tasks can select a unit by index
    always_comb begin
        rdy_v[0] = rdy_a;   rdy_v[1] = rdy_b;   rdy_v[2] = rdy_c;   rdy_v[3] = rdy_d;
        ov_v[0]  = ov_a;    ov_v[1]  = ov_b;    ov_v[2]  = ov_c;    ov_v[3]  = ov_d;
        dout_v[0] = dout_a; dout_v[1] = dout_b; dout_v[2] = dout_c; dout_v[3] = dout_d;
        addr_v[0] = addr_a; addr_v[1] = addr_b; addr_v[2] = addr_c; addr_v[3] = addr_d;
    end

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample to unit u, then wait for its output; lat counts cycles
    // from the accept cycle to the dout_valid cycle
    task automatic applyStimulus(input int u, input logic signed [17:0] x,
                                 output logic signed [17:0] y, output int lat);
        int n;
        n = 0;
        y = '0;
        lat = -1;
        @(negedge clock);
        while (!rdy_v[u] && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!rdy_v[u]) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        din_v[u] = x;
        dval_v[u] = 1'b1;
        @(negedge clock);
        dval_v[u] = 1'b0;
        din_v[u] = '0;
        lat = 1;
        while (!ov_v[u] && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        if (!ov_v[u])
            checkOutput("dout_valid_timeout", 0, 1);
        y = dout_v[u];
    endtask

    logic signed [17:0] y;
    int lat;
    int acc_c[$];
    int dv_c[$];
    int seen_ov;
    int n;

    // Directed test sequence
    initial begin
        for (int u = 0; u < 4; u++) begin
            rst_v[u] = 1'b1;
            din_v[u] = '0;
            dval_v[u] = 1'b0;
            for (int a = 0; a < 128; a++)
                rom[u][a] = '0;
        end
        for (int a = 0; a < 64; a++)
            rom[0][a] = 18'(a + 1);
        rom[1][0] = 18'sh10000;
        for (int a = 0; a < 4; a++)
            rom[2][a] = 18'(a + 1);
        for (int a = 0; a < 128; a++)
            rom[3][a] = 18'sh1FFFF;

        repeat (3) @(negedge clock);
        checkOutput("rst_ready", longint'(rdy_v[0]), 0);
        checkOutput("rst_dout", dout_v[0], 0);
        checkOutput("rst_dout_valid", longint'(ov_v[0]), 0);
        checkOutput("rst_coef_addr", addr_v[0], 0);
        for (int u = 0; u < 4; u++)
            rst_v[u] = 1'b0;
        @(negedge clock);
        checkOutput("idle_ready", longint'(rdy_v[0]), 1);

        // Impulse response, 64 taps, h[k]=k+1
        for (int i = 0; i < 65; i++) begin
            applyStimulus(0, (i == 0) ? 18'sd1 : 18'sd0, y, lat);
            checkOutput($sformatf("impulse_%0d", i), y, (i < 64) ? i + 1 : 0);
            if (i == 0) begin
                checkOutput("latency_64", lat, 66);
                @(negedge clock);
                checkOutput("pulse_width", longint'(ov_v[0]), 0);
            end
        end

        // Handshake with din_valid held high
        din_v[0] = '0;
        dval_v[0] = 1'b1;
        for (int c = 0; c < 210; c++) begin
            @(negedge clock);
            if (rdy_v[0]) acc_c.push_back(c);
            if (ov_v[0]) dv_c.push_back(c);
        end
        dval_v[0] = 1'b0;
        checkOutput("accept_count", acc_c.size(), 4);
        checkOutput("dv_count", dv_c.size(), 3);
        if (acc_c.size() >= 3 && dv_c.size() >= 2) begin
            checkOutput("accept_gap_1", acc_c[1] - acc_c[0], 67);
            checkOutput("accept_gap_2", acc_c[2] - acc_c[1], 67);
            checkOutput("dv_after_accept_1", dv_c[0] - acc_c[0], 66);
            checkOutput("dv_after_accept_2", dv_c[1] - acc_c[1], 66);
        end else begin
            checkOutput("handshake_events", 0, 1);
        end

        // Leave a nonzero dout and history, then reset in the middle of MAC
        applyStimulus(0, 18'sd1, y, lat);
        checkOutput("pre_reset_out", y, 1);
        n = 0;
        @(negedge clock);
        while (!rdy_v[0] && n < 300) begin
            @(negedge clock);
            n++;
        end
        din_v[0] = 18'sd5;
        dval_v[0] = 1'b1;
        @(negedge clock);
        dval_v[0] = 1'b0;
        din_v[0] = '0;
        seen_ov = 0;
        repeat (9) begin
            @(negedge clock);
            if (ov_v[0]) seen_ov++;
        end
        rst_v[0] = 1'b1;
        @(negedge clock);
        checkOutput("ready_in_reset", longint'(rdy_v[0]), 0);
        rst_v[0] = 1'b0;
        @(negedge clock);
        checkOutput("ready_after_reset", longint'(rdy_v[0]), 1);
        checkOutput("dout_after_reset", dout_v[0], 0);
        repeat (80) begin
            @(negedge clock);
            if (ov_v[0]) seen_ov++;
        end
        checkOutput("aborted_no_valid", seen_ov, 0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(0, (i == 0) ? 18'sd1 : 18'sd0, y, lat);
            checkOutput($sformatf("post_reset_impulse_%0d", i), y, i + 1);
        end

        // Rounding, single tap h[0]=0.5
        applyStimulus(1, 18'sd3, y, lat);
        checkOutput("round_p3", y, 2);
        checkOutput("latency_1", lat, 3);
        applyStimulus(1, -18'sd3, y, lat);
        checkOutput("round_m3", y, -1);
        applyStimulus(1, 18'sd1, y, lat);
        checkOutput("round_p1", y, 1);

        // Pointer wrap with four taps
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2, (i % 4 == 0) ? 18'sd1 : 18'sd0, y, lat);
            checkOutput($sformatf("wrap_%0d", i), y, (i % 4) + 1);
            if (i == 0) checkOutput("latency_4", lat, 6);
        end

        // Saturation, all h=0x1FFFF
        for (int i = 0; i < 64; i++) begin
            applyStimulus(3, 18'sd131071, y, lat);
            if (i == 0) checkOutput("sat_first_unclamped", y, 131070);
        end
        checkOutput("sat_pos_final", y, 131071);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(3, -18'sd131072, y, lat);
            if (i == 31) checkOutput("sat_mid_unclamped", y, -32);
        end
        checkOutput("sat_neg_final", y, -131072);
`ifdef FIR_SAT_CNT_EN
        checkOutput("sat_cnt", satc_d, 126);
        checkOutput("sat_cnt_other", satc_a, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
